// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, NOP, field positions.
// The ERR state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package ifetch_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;
`endif

endpackage

// File: rtl/ifetch_pc.sv
// Program counter: reset value, sequential +4 advance and redirect load.
// FETCH_MISALIGN_TRAP_EN exposes a misalignment flag; otherwise targets are word-aligned.
module ifetch_pc
    import ifetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] target_i,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misalign_o,
`endif
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] target_aligned;

    assign target_aligned = target_i & ~{{(XLEN-2){1'b0}}, 2'b11};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_o = |target_i[1:0];
`endif

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_aligned;
        end else if (advance_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch FSM with redirect/kill handling and decoded field outputs.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into a sticky ERR state.
//
//   state | meaning
//   FETCH | issue one memory request at pc
//   WAIT  | request outstanding; kill_q drops the response after a redirect
//   VALID | instruction held on inst_* until decode accepts (stall=0)
//   ERR   | misaligned redirect seen; idle until reset (trap build only)
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          XLEN     = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            misalign_err
);

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            pc_load;
    logic            pc_adv;
    logic [XLEN-1:0] pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
    logic            redirect_bad;
`endif

    ifetch_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC[XLEN-1:0])
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance_i  (pc_adv),
        .load_i     (pc_load),
        .target_i   (redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_o (redirect_bad),
`endif
        .pc_o       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            kill_q     <= 1'b0;
            inst_q     <= NOP_INST;
            inst_pc_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        pc_load   = 1'b0;
        pc_adv    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
        if (state_q != ST_ERR && redirect_valid && redirect_bad) begin
            state_d    = ST_ERR;
            misalign_d = 1'b1;
            kill_d     = 1'b0;
        end else
`endif
        begin
            case (state_q)
                ST_FETCH: begin
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A redirect coinciding with the response discards it immediately.
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                        if (imem_rvalid) begin
                            kill_d  = 1'b0;
                            state_d = ST_FETCH;
                        end else begin
                            kill_d = 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = ST_FETCH;
                        end else begin
                            inst_d    = imem_rdata;
                            inst_pc_d = pc;
                            state_d   = ST_VALID;
                        end
                    end
                end
                ST_VALID: begin
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                        state_d = ST_FETCH;
                    end else if (!stall) begin
                        pc_adv  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                ST_ERR: begin
                    state_d = ST_ERR;
                end
`endif
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // A redirect in FETCH suppresses the request so no orphan response can follow.
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        if (state_q == ST_FETCH) begin
            imem_req = rst_n & ~redirect_valid;
        end
        if (state_q == ST_VALID) begin
            inst_valid = 1'b1;
        end
    end

    assign imem_addr = pc;
    assign inst      = inst_q;
    assign inst_pc   = inst_pc_q;
    assign opcode    = inst_q[OPCODE_MSB:OPCODE_LSB];
    assign rd        = inst_q[RD_MSB:RD_LSB];
    assign funct3    = inst_q[FUNCT3_MSB:FUNCT3_LSB];
    assign rs1       = inst_q[RS1_MSB:RS1_LSB];
    assign rs2       = inst_q[RS2_MSB:RS2_LSB];
    assign funct7    = inst_q[FUNCT7_MSB:FUNCT7_LSB];

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios, then random redirect/stall/latency traffic
// checked by a transaction-level scoreboard. Honors FETCH_MISALIGN_TRAP_EN.
module tb_ifetch_unit;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        stall = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic        misalign_err;

    ifetch_unit #(.RESET_PC(64'h0), .XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: per-address overrides, otherwise an address-derived word.
    logic [31:0] mem_ovr [logic [63:0]];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {a[26:2] ^ a[56:32], 7'b0110011};
    endfunction

    int          mem_lat = 1;
    bit          rand_lat = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_pend = 32'h0;

    always begin
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_pend;
            end
        end
        #1;
        if (imem_req === 1'b1) begin
            mem_cnt  = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
            mem_pend = mem_word(imem_addr);
        end
    end

    // Reference model: next expected fetch address and the instruction each live fetch must deliver.
    logic [63:0] fetch_q[$];
    exp_t        inst_q[$];
    bit          live = 1'b0;
    bit          held = 1'b0;
    logic [63:0] out_pc = 64'h0;
    logic [63:0] held_pc = 64'h0;
    bit          mon_en = 1'b0;
    int          delivered = 0;

    task automatic model_step();
        exp_t t;
        if (held) begin
            if (redirect_valid) held = 1'b0;
            else if (!stall) begin
                fetch_q.push_back(held_pc + 64'd4);
                held = 1'b0;
            end
        end
        if (redirect_valid) begin
            live = 1'b0;
            fetch_q.delete();
            fetch_q.push_back({redirect_pc[63:2], 2'b00});
        end
        if (imem_req) begin
            live   = 1'b1;
            out_pc = (fetch_q.size() > 0) ? fetch_q[0] : imem_addr;
        end
        if (imem_rvalid && live) begin
            t.pc = out_pc;
            t.w  = mem_word(out_pc);
            inst_q.push_back(t);
            live    = 1'b0;
            held    = 1'b1;
            held_pc = out_pc;
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT fetches or presents a new instruction.
    logic        pv = 1'b0, pst = 1'b0, prd = 1'b0;
    logic [31:0] pinst = 32'h0;
    logic [63:0] ppc = 64'h0;
    exp_t        mon_e;

    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (imem_req) begin
                if (fetch_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_unexpected: addr %0h with no fetch expected", imem_addr);
                end else begin
                    chk("fetch_addr", imem_addr, fetch_q.pop_front());
                end
            end
            if (inst_valid && !pv) begin
                if (inst_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL inst_unexpected: pc %0h inst %0h with none expected", inst_pc, inst);
                end else begin
                    mon_e = inst_q.pop_front();
                    chk("inst_pc", inst_pc, mon_e.pc);
                    chk("inst", inst, mon_e.w);
                    chk("fields", {opcode, rd, funct3, rs1, rs2, funct7},
                        {mon_e.w[6:0], mon_e.w[11:7], mon_e.w[14:12], mon_e.w[19:15],
                         mon_e.w[24:20], mon_e.w[31:25]});
                    delivered++;
                end
            end
            if (pv && pst && !prd) begin
                chk("hold_valid", inst_valid, 1);
                chk("hold_inst", {inst_pc, inst}, {ppc, pinst});
                chk("hold_noreq", imem_req, 0);
            end
            if (pv && (prd || !pst)) chk("drop_valid", inst_valid, 0);
            chk("misalign_clear", misalign_err, 0);
        end
        pv    = inst_valid;
        pst   = stall;
        prd   = redirect_valid;
        pinst = inst;
        ppc   = inst_pc;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    bit got, stale;

    initial begin
        mem_ovr[64'h0] = 32'h0000_0033;
        mem_ovr[64'h4] = 32'h4000_0033;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_misalign", misalign_err, 0);

        // Basic fetch with 1-cycle memory
        @(negedge clk); rst_n = 1'b1; #1;
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        @(negedge clk); #1;
        chk("c1_no_valid", inst_valid, 0);
        @(negedge clk); #1;
        chk("c2_valid", inst_valid, 1);
        chk("c2_inst", inst, 32'h0000_0033);
        chk("c2_opcode", opcode, 7'b0110011);
        chk("c2_funct3", funct3, 3'b000);
        chk("c2_funct7", funct7, 7'b0000000);
        @(negedge clk); stall = 1'b1; #1;
        chk("next_req", imem_req, 1);
        chk("next_addr", imem_addr, 64'h4);

        // Stall holds the instruction
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("stall_valid", inst_valid, 1);
        chk("stall_inst", inst, 32'h4000_0033);
        chk("stall_pc", inst_pc, 64'h4);
        chk("stall_funct7", funct7, 7'b0100000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("stall_hold", {inst_valid, imem_req, inst, funct7}, {1'b1, 1'b0, 32'h4000_0033, 7'b0100000});
        end
        @(negedge clk); stall = 1'b0; #1;
        chk("unstall_valid", inst_valid, 1);
        @(negedge clk); mem_lat = 4; stall = 1'b1; #1;
        chk("unstall_req", imem_req, 1);
        chk("unstall_addr", imem_addr, 64'h8);

        // Redirect during WAIT with 4-cycle memory
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h100; #1;
        chk("wait_redirect_noreq", imem_req, 0);
        got = 1'b0; stale = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk); redirect_valid = 1'b0; #1;
            if (inst_valid) stale = 1'b1;
            if (imem_req) got = 1'b1;
        end
        chk("stale_dropped", stale, 0);
        chk("redirect_fetch_seen", got, 1);
        chk("redirect_fetch_addr", imem_addr, 64'h100);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk); #1;
            if (inst_valid) got = 1'b1;
        end
        chk("redirect_inst_seen", got, 1);
        chk("redirect_inst_pc", inst_pc, 64'h100);
        chk("redirect_inst", inst, mem_word(64'h100));

        // Redirect beats stall in VALID
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h200; mem_lat = 1; #1;
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("prio_drop", inst_valid, 0);
        chk("prio_req", imem_req, 1);
        chk("prio_addr", imem_addr, 64'h200);

        // Redirect coinciding with rvalid, then wrap from the top of the address space
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("top_req", imem_req, 1);
        chk("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("top_no_valid", inst_valid, 0);
        @(negedge clk); #1;
        @(negedge clk); stall = 1'b0; #1;
        chk("top_valid", inst_valid, 1);
        chk("top_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk); stall = 1'b1; #1;
        chk("wrap_req", imem_req, 1);
        chk("wrap_addr", imem_addr, 64'h0);

        // Misaligned redirect
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("mis_pre_valid", inst_valid, 1);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h102; #1;
        @(negedge clk); redirect_valid = 1'b0; #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_err", misalign_err, 1);
        chk("mis_noreq", imem_req, 0);
        chk("mis_novalid", inst_valid, 0);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("err_idle", {imem_req, inst_valid, misalign_err}, {1'b0, 1'b0, 1'b1});
        end
        rst_n = 1'b0; #1;
        chk("err_reset_clears", misalign_err, 0);
`else
        chk("mis_req", imem_req, 1);
        chk("mis_addr", imem_addr, 64'h100);
        chk("mis_err", misalign_err, 0);
`endif

        // Random traffic against the scoreboard
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; rand_lat = 1'b1;
        repeat (6) @(negedge clk);
        fetch_q.delete();
        inst_q.delete();
        live = 1'b0;
        held = 1'b0;
        fetch_q.push_back(64'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        #1 model_step();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            stall = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            if (redirect_valid) begin
                if ($urandom_range(0, 4) == 0)
                    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                else
                    redirect_pc = {$urandom, $urandom};
`ifdef FETCH_MISALIGN_TRAP_EN
                redirect_pc[1:0] = 2'b00;
`endif
            end
            #1 model_step();
        end
        @(negedge clk); redirect_valid = 1'b0; stall = 1'b0;
        @(negedge clk); mon_en = 1'b0;
        checks++;
        if (delivered < 100) begin
            failures++;
            $display("FAIL progress: delivered %0d instructions, required at least 100", delivered);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
